// File: rtl/avl_mem_responder_if.sv
// Avalon-MM bus between the CPU-side master and the memory responder.
interface avl_mem_responder_if #(
  parameter int RAM_ADDR_W = 26,
  parameter int RAM_DATA_W = 128
);
  logic [RAM_ADDR_W-1:0] avl_address;
  logic                  avl_read;
  logic                  avl_write;
  logic [RAM_DATA_W-1:0] avl_writedata;
  logic                  avl_wait;
  logic                  avl_readdatavalid;
  logic [RAM_DATA_W-1:0] avl_readdata;

  modport master (
    output avl_address, avl_read, avl_write, avl_writedata,
    input  avl_wait, avl_readdatavalid, avl_readdata
  );

  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata,
    output avl_wait, avl_readdatavalid, avl_readdata
  );
endinterface

// File: rtl/avl_mem_responder.sv
// On-chip RAM behind an Avalon-MM slave: fixed-latency pipelined reads,
// bounded outstanding reads and a one-cycle stall after every write.
module avl_mem_responder #(
  parameter int RAM_ADDR_W   = 26,
  parameter int RAM_DATA_W   = 128,
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 3,
  parameter int MAX_PENDING  = 2
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  avl_mem_responder_if.slave   avl,
  output logic                 err_sticky
);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef enum logic {IDLE, WR_HOLD} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PEND_W-1:0]     r_pend_cnt;
  logic [READ_LATENCY-1:0] r_vld;
  logic [RAM_DATA_W-1:0] r_dat [READ_LATENCY];
  logic [RAM_DATA_W-1:0] r_mem [2**MEM_AW];
  logic                  r_err;

  logic [MEM_AW-1:0]     w_idx;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_conflict;
  logic                  w_rsp_done;
  logic                  w_addr_unused;

  assign w_idx         = avl.avl_address[MEM_AW-1:0];
  assign w_addr_unused = ^avl.avl_address[RAM_ADDR_W-1:MEM_AW];

  // A write always wins; a read presented together with it is dropped.
  assign w_wr_acc   = avl.avl_write & ~avl.avl_wait;
  assign w_rd_acc   = avl.avl_read & ~avl.avl_write & ~avl.avl_wait;
  assign w_conflict = avl.avl_read & avl.avl_write & ~avl.avl_wait;
  assign w_rsp_done = r_vld[READ_LATENCY-1];

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_wr_acc) w_state_next = WR_HOLD;
      WR_HOLD: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    avl.avl_wait = iRST | (r_state == WR_HOLD) | (r_pend_cnt == PEND_W'(MAX_PENDING));
  end

  always_ff @(posedge iCLK) begin
    if (w_wr_acc) begin
      r_mem[w_idx] <= avl.avl_writedata;
    end
  end

  // Data stages only advance behind a valid bit, so the last stage keeps
  // the most recent response between pulses.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= r_mem[w_idx];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_dat[i] <= r_dat[i-1];
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_pend_cnt <= '0;
    end else begin
      case ({w_rd_acc, w_rsp_done})
        2'b10:   r_pend_cnt <= r_pend_cnt + PEND_W'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - PEND_W'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_err <= 1'b0;
    end else if (w_conflict) begin
      r_err <= 1'b1;
    end
  end

  assign avl.avl_readdatavalid = r_vld[READ_LATENCY-1];
  assign avl.avl_readdata      = r_dat[READ_LATENCY-1];
  assign err_sticky            = r_err;
endmodule

// File: tb/tb_avl_mem_responder.sv
// Directed and randomized checks of avl_mem_responder against a queue-based
// model of the Avalon read/write rules.
module tb_avl_mem_responder;
  localparam int AW = 26;
  localparam int DW = 128;
  localparam int RL = 3;
  localparam int MP = 2;

  typedef struct {
    int           due;
    logic [DW-1:0] data;
  } rsp_t;

  logic iCLK;
  logic iRST;
  logic err_sticky;

  avl_mem_responder_if #(.RAM_ADDR_W(AW), .RAM_DATA_W(DW)) avl ();

  avl_mem_responder #(
    .RAM_ADDR_W(AW), .RAM_DATA_W(DW), .MEM_AW(10),
    .READ_LATENCY(RL), .MAX_PENDING(MP)
  ) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .avl(avl),
    .err_sticky(err_sticky)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int checks = 0;
  int failures = 0;

  // Model state: responses still owed, memory contents, write-hold and error flags.
  rsp_t          q[$];
  logic [DW-1:0] mmem[int];
  logic [DW-1:0] last_data;
  bit            m_hold;
  bit            m_err;
  int            cyc = 0;
  bit            last_acc;
  bit            started = 0;

  bit            exp_wait;
  bit            exp_rdv;
  bit            exp_err;
  logic [DW-1:0] exp_rdata;

  logic [DW-1:0] obs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hold    = 1'b0;
    m_err     = 1'b0;
    last_data = '0;
  endtask

  task automatic compute_exp(input bit rst);
    exp_wait = rst || m_hold || (q.size() == MP);
    exp_rdv  = (q.size() != 0) && (q[0].due == cyc);
    if (exp_rdv) last_data = q[0].data;
    exp_rdata = last_data;
    exp_err   = m_err;
  endtask

  // One clock cycle: drive inputs, step the model across the edge.
  task automatic cycle(input bit rst, input bit rd, input bit wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit mw, wa, ra, cf, pop;
    int idx;
    iRST              = rst;
    avl.avl_read      = rd;
    avl.avl_write     = wr;
    avl.avl_address   = a;
    avl.avl_writedata = d;
    if (rst) model_reset();
    compute_exp(rst);
    mw  = exp_wait;
    wa  = wr && !mw;
    ra  = rd && !wr && !mw;
    cf  = rd && wr && !mw;
    pop = exp_rdv;
    @(posedge iCLK);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      idx = int'(a[9:0]);
      if (pop) q.delete(0);
      if (ra) q.push_back('{cyc + RL - 1, mmem.exists(idx) ? mmem[idx] : '0});
      m_hold = wa;
      if (wa) mmem[idx] = d;
      if (cf) m_err = 1'b1;
    end
    last_acc = wa || ra || cf;
    compute_exp(rst);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Hold a request until the model says it was taken, bounded.
  task automatic req(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    do begin
      cycle(1'b0, rd, wr, a, d);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      failures++;
      $display("FAIL req_timeout act=not_accepted exp=accepted addr=%0h", a);
    end
  endtask

  task automatic settle();
    @(negedge iCLK);
    #1;
  endtask

  always @(negedge iCLK) begin
    if (started) begin
      chk("avl_wait", 128'(avl.avl_wait), 128'(exp_wait));
      chk("avl_readdatavalid", 128'(avl.avl_readdatavalid), 128'(exp_rdv));
      chk("avl_readdata", avl.avl_readdata, exp_rdata);
      chk("err_sticky", 128'(err_sticky), 128'(exp_err));
      if (avl.avl_readdatavalid === 1'b1) begin
        obs.push_back(avl.avl_readdata);
        $display("rsp t=%0t data=%0h", $time, avl.avl_readdata);
      end
    end
  end

  localparam logic [DW-1:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  initial begin
    int n0;
    logic [DW-1:0] v;
    iRST = 1'b1;
    avl.avl_read = 1'b0;
    avl.avl_write = 1'b0;
    avl.avl_address = '0;
    avl.avl_writedata = '0;
    model_reset();
    started = 1;

    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);

    // Write then read-after-write with the fixed latency.
    cycle(1'b0, 1'b0, 1'b1, 26'h005, D1);
    settle(); chk("lit_wait_wrhold", 128'(avl.avl_wait), 128'(1));
    cycle(1'b0, 1'b1, 1'b0, 26'h005, '0);
    settle(); chk("lit_wait_after_hold", 128'(avl.avl_wait), 128'(0));
    cycle(1'b0, 1'b1, 1'b0, 26'h005, '0);
    settle(); chk("lit_rdv_e3", 128'(avl.avl_readdatavalid), 128'(0));
    idle(1);
    settle(); chk("lit_rdv_e4", 128'(avl.avl_readdatavalid), 128'(0));
    idle(1);
    settle(); chk("lit_rdv_e5", 128'(avl.avl_readdatavalid), 128'(1));
    chk("lit_rdata_raw", avl.avl_readdata, D1);
    idle(1);
    settle(); chk("lit_rdv_e6", 128'(avl.avl_readdatavalid), 128'(0));
    chk("lit_rdata_hold", avl.avl_readdata, D1);

    // Preload words 0..15; 1..4 hold 0x11..0x44.
    for (int i = 0; i < 16; i++) begin
      v = (i >= 1 && i <= 4) ? DW'(32'h11 * i) : {$urandom, $urandom, $urandom, $urandom};
      req(1'b0, 1'b1, AW'(i), v);
    end
    n0 = obs.size();
    req(1'b1, 1'b0, 26'd1, '0);
    req(1'b1, 1'b0, 26'd2, '0);
    settle(); chk("lit_wait_full", 128'(avl.avl_wait), 128'(1));
    req(1'b1, 1'b0, 26'd3, '0);
    req(1'b1, 1'b0, 26'd4, '0);
    idle(6);
    chk("lit_pulse_count", 128'(obs.size() - n0), 128'(4));
    for (int j = 0; j < 4; j++) begin
      if (obs.size() > n0 + j) chk("lit_order", obs[n0 + j], DW'(32'h11 * (j + 1)));
    end

    // Upper address bits alias onto the array.
    req(1'b0, 1'b1, 26'h400, 128'hAA);
    req(1'b1, 1'b0, 26'h000, '0);
    idle(5);
    chk("lit_alias", obs[$], 128'hAA);

    // Read and write together: write lands, read dropped, error latched.
    idle(1);
    n0 = obs.size();
    req(1'b1, 1'b1, 26'h007, 128'h55);
    idle(6);
    settle(); chk("lit_err_set", 128'(err_sticky), 128'(1));
    chk("lit_no_rsp_conflict", 128'(obs.size()), 128'(n0));
    req(1'b1, 1'b0, 26'h007, '0);
    idle(5);
    chk("lit_conflict_write", obs[$], 128'h55);
    chk("lit_err_kept", 128'(err_sticky), 128'(1));

    // Reset with two reads in flight discards them.
    req(1'b1, 1'b0, 26'd1, '0);
    req(1'b1, 1'b0, 26'd2, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    settle(); chk("lit_wait_in_rst", 128'(avl.avl_wait), 128'(1));
    n0 = obs.size();
    idle(6);
    settle(); chk("lit_wait_after_rst", 128'(avl.avl_wait), 128'(0));
    chk("lit_err_cleared", 128'(err_sticky), 128'(0));
    chk("lit_no_rsp_after_rst", 128'(obs.size()), 128'(n0));
    req(1'b1, 1'b0, 26'd3, '0);
    settle(); chk("lit_pend_cleared", 128'(avl.avl_wait), 128'(0));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 80) == 0, 1'($urandom % 2), ($urandom % 4) == 0,
            {16'($urandom), 10'($urandom_range(0, 15))},
            {$urandom, $urandom, $urandom, $urandom});
    end
    idle(6);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
